// File: rtl/mux_rr_stream_pkg.sv
// Shared definitions for the stream multiplexer: mode constants and select-width helper.
package mux_rr_stream_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Width of a channel index: at least one bit even for tiny N.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_stream_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping around.
module rr_arbiter
    import mux_rr_stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [N-1:0] upper_req;
    logic [N-1:0] pick;

    // Prefer requesters at or above ptr; if none, fall back to the lowest requester overall (the wrap).
    always_comb begin
        upper_req = '0;
        pick      = '0;
        grant     = '0;
        idx       = '0;
        any       = |req;
        for (int k = 0; k < N; k++) begin
            upper_req[k] = req[k] && (32'(ptr) <= k);
        end
        pick = (|upper_req) ? upper_req : req;
        for (int k = N - 1; k >= 0; k--) begin
            if (pick[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = SW'(k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-to-1 stream multiplexer with a one-entry output register, explicit-select or round-robin.
module mux_rr_stream
    import mux_rr_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = MODE_SEL,
    localparam int SW   = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_chan
);

    logic             load_ok;
    logic [N-1:0]     grant_onehot;
    logic [SW-1:0]    grant_idx;
    logic             in_xfer;
    logic [WIDTH-1:0] grant_word;

    assign load_ok = !out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SW-1:0] ptr;
            logic          rr_any;
            logic          sel_unused;

            assign sel_unused = ^sel;

            rr_arbiter #(.N(N), .SW(SW)) u_arb (
                .req   (in_valid),
                .ptr   (ptr),
                .grant (grant_onehot),
                .idx   (grant_idx),
                .any   (rr_any)
            );

            // Advance the search start to just past the channel that was served.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr <= '0;
                end else if (in_xfer && rr_any) begin
                    ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + SW'(1);
                end
            end
        end else begin : g_sel
            // Only the selected channel can be granted; an out-of-range select grants nothing.
            always_comb begin
                grant_onehot = '0;
                for (int k = 0; k < N; k++) begin
                    grant_onehot[k] = in_valid[k] && (32'(sel) == k);
                end
            end
            assign grant_idx = sel;
        end
    endgenerate

    // Ready goes to the granted channel only when the output register can take a word.
    assign in_ready = (rst || !load_ok) ? '0 : grant_onehot;
    assign in_xfer  = |in_ready;

    // Pick the granted channel's word; grant is one-hot so an OR-mux suffices.
    always_comb begin
        grant_word = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_onehot[k]) begin
                grant_word = grant_word | in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load on input transfer, empty on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_word;
            out_chan  <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
